// File: rtl/fast_message_sequencer.sv
// fast_message_sequencer: serializes groups of aligned FAST field lanes into a
// single field stream tagged PMAP / TID / BODY, with message-end marking and a
// writable per-template body-count table.
// Optional build macro FAST_SEQ_STATS_EN adds stat_msgs / stat_errs counters.
module fast_message_sequencer #(
   parameter int BEAT_WIDTH       = 64,
   parameter int SUP_PATHS        = 4,
   parameter int NUM_TEMPLATES    = 4,
   parameter int MAX_MESSAGE_SIZE = 10,
   parameter int TIDX             = $clog2(NUM_TEMPLATES),
   parameter int CW               = $clog2(MAX_MESSAGE_SIZE + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [SUP_PATHS*BEAT_WIDTH-1:0] in_fields,
   input  logic [SUP_PATHS-1:0]            in_valid,
   input  logic [SUP_PATHS-1:0]            in_complete,
   input  logic                            in_group_valid,
   output logic                            in_ready,
   output logic [BEAT_WIDTH-1:0]           out_field,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [1:0]                      out_kind,
   output logic                            out_frag_last,
   output logic                            out_msg_end,
   input  logic                            cfg_we,
   input  logic [TIDX-1:0]                 cfg_tidx,
   input  logic [CW-1:0]                   cfg_count,
   output logic [CW-1:0]                   msg_field_count,
   output logic                            err_unknown_tid
`ifdef FAST_SEQ_STATS_EN
   ,
   output logic [31:0]                     stat_msgs,
   output logic [15:0]                     stat_errs
`endif
);

   localparam int LW     = (SUP_PATHS > 1) ? $clog2(SUP_PATHS) : 1;
   localparam int TDEPTH = 1 << TIDX;

   typedef enum logic [1:0] {
      S_PMAP = 2'd0,
      S_TID  = 2'd1,
      S_BODY = 2'd2
   } state_t;

   state_t                 state, state_nx;
   logic [CW-1:0]          remaining, rem_nx;
   logic                   err_set, cnt_load;
   logic                   live;

   logic [BEAT_WIDTH-1:0]  grp_data [SUP_PATHS];
   logic [SUP_PATHS-1:0]   grp_cmpl;
   logic [SUP_PATHS-1:0]   pend;
   logic [SUP_PATHS-1:0]   pend_left;
   logic [SUP_PATHS-1:0]   src_mask;
   logic [LW-1:0]          cur, sel;

   logic [CW-1:0]          table_q [TDEPTH];

   // Lookup result travels with the presented field so the commit at handshake
   // uses exactly the value that decided out_msg_end.
   logic                   o_known;
   logic [CW-1:0]          o_count;

   logic                   fire, accept, found, load;
   logic [BEAT_WIDTH-1:0]  ld_data;
   logic                   ld_cmpl, ld_known, ld_msg_end;
   logic [TIDX-1:0]        ld_tidx;
   logic [CW-1:0]          ld_count;

   assign fire = out_valid & out_ready;

   // Message FSM: advances only when a complete fragment is handed off.
   always_comb begin
      state_nx = state;
      rem_nx   = remaining;
      err_set  = 1'b0;
      cnt_load = 1'b0;
      if (fire && out_frag_last) begin
         unique case (state)
            S_PMAP: state_nx = S_TID;
            S_TID: begin
               if (o_known) begin
                  state_nx = S_BODY;
                  rem_nx   = o_count;
                  cnt_load = 1'b1;
               end else begin
                  state_nx = S_PMAP;
                  err_set  = 1'b1;
               end
            end
            S_BODY: begin
               rem_nx = remaining - CW'(1);
               if (out_msg_end) state_nx = S_PMAP;
            end
            default: state_nx = S_PMAP;
         endcase
      end
   end

   // Lane selection and output-register load; the loaded field is tagged with
   // the post-handshake state so a back-to-back load sees the advanced FSM.
   always_comb begin
      pend_left = pend;
      if (fire) pend_left = pend & ~(SUP_PATHS'(1) << cur);
      in_ready = live & ~rst & (pend_left == '0);
      accept   = in_group_valid & in_ready;
      src_mask = accept ? in_valid : pend_left;
      found    = 1'b0;
      sel      = '0;
      ld_data  = '0;
      ld_cmpl  = 1'b0;
      for (int unsigned i = 0; i < SUP_PATHS; i++) begin
         if (src_mask[i] && !found) begin
            found   = 1'b1;
            sel     = LW'(i);
            ld_data = accept ? in_fields[i*BEAT_WIDTH +: BEAT_WIDTH] : grp_data[i];
            ld_cmpl = accept ? in_complete[i] : grp_cmpl[i];
         end
      end
      load       = found & (accept | fire);
      ld_tidx    = ld_data[TIDX-1:0];
      ld_count   = table_q[ld_tidx];
      ld_known   = ((ld_data >> TIDX) == '0) && (ld_count != '0);
      ld_msg_end = 1'b0;
      if (ld_cmpl) begin
         if (state_nx == S_TID)       ld_msg_end = ~ld_known;
         else if (state_nx == S_BODY) ld_msg_end = (rem_nx == CW'(1));
      end
   end

   // Group payload storage; only meaningful where pend is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned i = 0; i < SUP_PATHS; i++)
            grp_data[i] <= in_fields[i*BEAT_WIDTH +: BEAT_WIDTH];
         grp_cmpl <= in_complete;
      end
   end

   // Control state, output register, template table and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         live            <= 1'b0;
         state           <= S_PMAP;
         remaining       <= '0;
         pend            <= '0;
         cur             <= '0;
         out_valid       <= 1'b0;
         out_field       <= '0;
         out_kind        <= '0;
         out_frag_last   <= 1'b0;
         out_msg_end     <= 1'b0;
         o_known         <= 1'b0;
         o_count         <= '0;
         msg_field_count <= '0;
         err_unknown_tid <= 1'b0;
         for (int unsigned t = 0; t < TDEPTH; t++) table_q[t] <= '0;
      end else begin
         live      <= 1'b1;
         state     <= state_nx;
         remaining <= rem_nx;
         if (cnt_load) msg_field_count <= o_count;
         if (err_set)  err_unknown_tid <= 1'b1;
         if (cfg_we && (int'(cfg_tidx) < NUM_TEMPLATES)) table_q[cfg_tidx] <= cfg_count;
         pend <= accept ? in_valid : pend_left;
         if (load) begin
            out_valid     <= 1'b1;
            out_field     <= ld_data;
            out_kind      <= state_nx;
            out_frag_last <= ld_cmpl;
            out_msg_end   <= ld_msg_end;
            o_known       <= ld_known;
            o_count       <= ld_count;
            cur           <= sel;
         end else if (fire) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef FAST_SEQ_STATS_EN
   // Saturating message and unknown-template counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_msgs <= '0;
         stat_errs <= '0;
      end else begin
         if (fire && out_msg_end && (stat_msgs != '1)) stat_msgs <= stat_msgs + 32'd1;
         if (err_set && (stat_errs != '1))             stat_errs <= stat_errs + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fast_message_sequencer.sv
// Self-checking bench for fast_message_sequencer: directed scenarios followed by
// randomized traffic, scored against a message-position reference model.
module tb_fast_message_sequencer;

   localparam int BW   = 64;
   localparam int SP   = 4;
   localparam int NT   = 4;
   localparam int MMS  = 10;
   localparam int TIDX = 2;
   localparam int CW   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [SP*BW-1:0]  in_fields;
   logic [SP-1:0]     in_valid, in_complete;
   logic              in_group_valid, in_ready;
   logic [BW-1:0]     out_field;
   logic              out_valid, out_ready;
   logic [1:0]        out_kind;
   logic              out_frag_last, out_msg_end;
   logic              cfg_we;
   logic [TIDX-1:0]   cfg_tidx;
   logic [CW-1:0]     cfg_count;
   logic [CW-1:0]     msg_field_count;
   logic              err_unknown_tid;

   always #5 clk = ~clk;

   fast_message_sequencer #(
      .BEAT_WIDTH(BW), .SUP_PATHS(SP), .NUM_TEMPLATES(NT), .MAX_MESSAGE_SIZE(MMS)
   ) dut (
      .clk(clk), .rst(rst), .in_fields(in_fields), .in_valid(in_valid),
      .in_complete(in_complete), .in_group_valid(in_group_valid), .in_ready(in_ready),
      .out_field(out_field), .out_valid(out_valid), .out_ready(out_ready),
      .out_kind(out_kind), .out_frag_last(out_frag_last), .out_msg_end(out_msg_end),
      .cfg_we(cfg_we), .cfg_tidx(cfg_tidx), .cfg_count(cfg_count),
      .msg_field_count(msg_field_count), .err_unknown_tid(err_unknown_tid)
   );

   typedef struct {
      logic [63:0] f;
      logic [1:0]  k;
      logic        fl;
      logic        me;
   } rec_t;

   rec_t  q[$];
   int    checks = 0;
   int    errors = 0;
   int    m_tbl [NT];
   int    m_pos, m_len, m_cnt;
   bit    m_err;
   bit    p_stall;
   logic [63:0] p_field;
   logic [3:0]  p_ctl;
   bit    dummy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: position of the field inside its message decides the kind;
   // a complete TID fixes the message length (2 + body count, or 2 if unknown).
   task automatic model_lane(input logic [63:0] f, input logic c);
      rec_t r;
      int   k;
      k    = (m_pos == 0) ? 0 : (m_pos == 1) ? 1 : 2;
      r.f  = f;
      r.k  = 2'(k);
      r.fl = c;
      r.me = 1'b0;
      if (c) begin
         if (k == 1) begin
            if (f < 64'(NT) && m_tbl[int'(f[1:0])] != 0) begin
               m_len = 2 + m_tbl[int'(f[1:0])];
               m_cnt = m_tbl[int'(f[1:0])];
            end else begin
               m_len = 2;
               m_err = 1'b1;
            end
         end
         r.me = (m_pos + 1 == m_len);
         if (r.me) begin
            m_pos = 0;
            m_len = 1000;
         end else begin
            m_pos++;
         end
      end
      q.push_back(r);
   endtask

   task automatic tick(output bit acc);
      rec_t r;
      acc = 1'b0;
      @(negedge clk);
      if (!rst) begin
         if (p_stall) begin
            check("stall_field", out_field, p_field);
            check("stall_ctl", 64'({out_valid, out_kind, out_frag_last, out_msg_end}),
                  64'({1'b1, p_ctl}));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               r = q.pop_front();
               check("out_field", out_field, r.f);
               check("out_ctl", 64'({out_kind, out_frag_last, out_msg_end}),
                     64'({r.k, r.fl, r.me}));
            end
         end
         p_stall = out_valid && !out_ready;
         p_field = out_field;
         p_ctl   = {out_kind, out_frag_last, out_msg_end};
         if (in_group_valid && in_ready) begin
            acc = 1'b1;
            for (int i = 0; i < SP; i++)
               if (in_valid[i]) model_lane(in_fields[i*BW +: BW], in_complete[i]);
         end
      end else begin
         p_stall = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] v, input logic [3:0] c,
                       input logic [63:0] f0, input logic [63:0] f1,
                       input logic [63:0] f2, input logic [63:0] f3);
      bit acc = 1'b0;
      in_fields      = {f3, f2, f1, f0};
      in_valid       = v;
      in_complete    = c;
      in_group_valid = 1'b1;
      for (int n = 0; n < 100 && !acc; n++) tick(acc);
      if (!acc) check("accept_timeout", 64'(in_ready), 64'd1);
      in_group_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 300 && (q.size() != 0 || out_valid); n++) tick(dummy);
      check("drain_empty", 64'(q.size()), 64'd0);
      check("drain_idle", 64'(out_valid), 64'd0);
   endtask

   task automatic write_tbl(input int idx, input int cnt);
      cfg_we    = 1'b1;
      cfg_tidx  = TIDX'(idx);
      cfg_count = CW'(cnt);
      tick(dummy);
      cfg_we    = 1'b0;
      m_tbl[idx] = cnt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete();
      m_pos = 0; m_len = 1000; m_err = 1'b0; m_cnt = 0;
      foreach (m_tbl[i]) m_tbl[i] = 0;
      p_stall = 1'b0;
      tick(dummy);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      tick(dummy);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_field", out_field, 64'd0);
      check("rst_ctl", 64'({out_kind, out_frag_last, out_msg_end}), 64'd0);
      check("rst_count", 64'(msg_field_count), 64'd0);
      check("rst_err", 64'(err_unknown_tid), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rdy_after_release", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rdy_idle", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] rnd_field();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) return 64'(r % 5);
      return {$urandom, $urandom};
   endfunction

   initial begin
      rst = 1'b1; in_fields = '0; in_valid = '0; in_complete = '0;
      in_group_valid = 1'b0; out_ready = 1'b0;
      cfg_we = 1'b0; cfg_tidx = '0; cfg_count = '0;
      do_reset();

      // Basic message: PMAP, TID=1 (3 bodies), B, B | B
      write_tbl(1, 3);
      out_ready = 1'b1;
      send(4'hF, 4'hF, 64'hAAAA, 64'h1, 64'h11, 64'h22);
      check("latency_valid", 64'(out_valid), 64'd1);
      check("latency_field", out_field, 64'hAAAA);
      send(4'h1, 4'h1, 64'h33, 64'h0, 64'h0, 64'h0);
      drain();
      check("msg_field_count", 64'(msg_field_count), 64'd3);

      // Sparse lanes 1 and 3
      send(4'b1010, 4'hF, 64'hDEAD, 64'h5, 64'hBEEF, 64'h1);
      check("sparse_first", out_field, 64'h5);
      check("sparse_rdy_low", 64'(in_ready), 64'd0);
      tick(dummy);
      check("sparse_second", out_field, 64'h1);
      check("sparse_rdy_high", 64'(in_ready), 64'd1);
      drain();

      // Back-pressure for five cycles mid-group
      out_ready = 1'b0;
      send(4'hF, 4'hF, 64'h100, 64'h101, 64'h102, 64'h200);
      for (int n = 0; n < 5; n++) begin
         tick(dummy);
         check("stall_rdy", 64'(in_ready), 64'd0);
      end
      drain();

      // Unknown TID 7, then a new message ending in a body fragment
      send(4'hF, 4'b0111, 64'h7, 64'h300, 64'h1, 64'h400);
      drain();
      check("err_sticky", 64'(err_unknown_tid), 64'd1);
      send(4'h7, 4'h7, 64'h401, 64'h402, 64'h403, 64'h0);
      drain();
      check("frag_count", 64'(msg_field_count), 64'd3);

      // Reset while in the body with a lane still pending
      write_tbl(2, 4);
      out_ready = 1'b0;
      send(4'hF, 4'hF, 64'h500, 64'h2, 64'h501, 64'h502);
      out_ready = 1'b1;
      for (int n = 0; n < 3; n++) tick(dummy);
      out_ready = 1'b0;
      tick(dummy);
      do_reset();
      out_ready = 1'b1;
      send(4'h3, 4'h3, 64'h600, 64'h1, 64'h0, 64'h0);
      drain();
      check("cleared_table_err", 64'(err_unknown_tid), 64'd1);
      check("cleared_table_cnt", 64'(msg_field_count), 64'd0);

      // Randomized traffic
      for (int i = 0; i < NT; i++) write_tbl(i, int'($urandom_range(0, MMS)));
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit acc;
         if (!in_group_valid && $urandom_range(0, 3) != 0) begin
            in_fields = {rnd_field(), rnd_field(), rnd_field(), rnd_field()};
            in_valid  = 4'($urandom);
            for (int i = 0; i < SP; i++) in_complete[i] = ($urandom_range(0, 4) != 0);
            in_group_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick(acc);
         if (acc) in_group_valid = 1'b0;
      end
      in_group_valid = 1'b0;
      drain();
      check("rand_err", 64'(err_unknown_tid), 64'(m_err));
      check("rand_count", 64'(msg_field_count), 64'(m_cnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fast_message_sequencer.md
Name: fast_message_sequencer

Overview:
Sequences decoding of FAST messages downstream of the superscalar field aligner. Each cycle it accepts a group of up to SUP_PATHS field lanes and serializes them into a single ordered field stream with valid/ready. It tags each field as PMAP, TID or BODY, looks up the body field count per template ID in a writable table, and marks message boundaries. It also drives the field-count configuration back to the aligner.

Parameters:
BEAT_WIDTH, 64, width of one field lane payload
SUP_PATHS, 4, lanes per input group
NUM_TEMPLATES, 4, template table depth; TIDX = $clog2(NUM_TEMPLATES)
MAX_MESSAGE_SIZE, 10, max body fields per template; CW = $clog2(MAX_MESSAGE_SIZE+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_fields  in  SUP_PATHS*BEAT_WIDTH  lane i at bits [i*BEAT_WIDTH +: BEAT_WIDTH]
in_valid  in  SUP_PATHS  lane holds a field or fragment
in_complete  in  SUP_PATHS  lane fragment ends its field
in_group_valid  in  1  group offered
in_ready  out  1  group accepted when in_group_valid & in_ready
out_field  out  BEAT_WIDTH  serialized fragment
out_valid  out  1  out_field valid
out_ready  in  1  consumer accepts
out_kind  out  2  0=PMAP, 1=TID, 2=BODY
out_frag_last  out  1  fragment completes its field
out_msg_end  out  1  field is last of message
cfg_we  in  1  template table write
cfg_tidx  in  TIDX  table index
cfg_count  in  CW  body field count
msg_field_count  out  CW  body count of current message, to aligner
err_unknown_tid  out  1  sticky error

Behaviour:
- Reset: in_ready=0, out_valid=0, out_kind=0, out_frag_last=0, out_msg_end=0, out_field=0, msg_field_count=0, err_unknown_tid=0, group register empty, FSM=S_PMAP, all table entries=0.
- in_ready=1 iff group register empty, or its last remaining lane transfers this cycle (out_valid & out_ready). Deasserted the cycle after reset release.
- Accepted group latched with mask pend = in_valid. Lanes emit in ascending index order, skipping pend=0 lanes; one lane per out handshake. Group with in_valid=0 accepted and dropped.
- Latency: group accepted cycle N -> first lane on out at N+1. Outputs registered; out_* stable while out_valid & ~out_ready.
- Fragment (in_complete=0) emits with out_frag_last=0, kind of current state; state advances only on complete fragments.
- FSM (advances on handshake of complete fragment):
  S_PMAP: kind=PMAP -> S_TID.
  S_TID: kind=TID; tidx=field[TIDX-1:0]; unknown if field[BEAT_WIDTH-1:TIDX]!=0 or table[tidx]==0. Known: remaining<=table[tidx], msg_field_count<=table[tidx], -> S_BODY. Unknown: err_unknown_tid<=1, out_msg_end=1 on this field, -> S_PMAP.
  S_BODY: kind=BODY, remaining decrements; at remaining==1 out_msg_end=1, -> S_PMAP.
- Template with count 0 is "unknown" (reserved invalid).
- cfg_we writes table next edge; lookup same cycle same index sees old value. Writes allowed anytime.
- err_unknown_tid cleared only by rst.
- Reset mid-message: group discarded, no partial output, FSM S_PMAP.

Optional Feature:
FAST_SEQ_STATS_EN: adds outputs stat_msgs[31:0] (increment per out_msg_end handshake, incl. unknown-TID) and stat_errs[15:0] (increment per unknown TID), both saturating, reset 0. Without the macro these ports and counters do not exist.

Test Plan:
- table[1]=3; group lanes 0-3 complete = PMAP, TID=1, B, B; next group lane0 B -> kinds 0,1,2,2,2; out_msg_end only on 5th; msg_field_count=3.
- in_valid=4'b1010 -> only lanes 1,3 emitted, in order; in_ready high on cycle lane 3 transfers.
- out_ready held low 5 cycles mid-group -> out_field/out_kind stable, in_ready=0, no loss.
- TID field=7 with NUM_TEMPLATES=4 -> err_unknown_tid=1, out_msg_end on TID, next field PMAP.
- Body fragment complete=0 then complete=1 -> two BODY outputs, frag_last 0 then 1; remaining decrements once.
- rst asserted during S_BODY with pending lanes -> next cycle out_valid=0, table cleared, following group starts at PMAP.
